// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, scan-code constants and event word layout
// for the PS/2 keyboard event decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } state_e;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam logic [7:0] RPL_ACK    = 8'hFA;
    localparam logic [7:0] RPL_BAT_OK = 8'hAA;
    localparam logic [7:0] RPL_ECHO   = 8'hEE;
    localparam logic [7:0] RPL_RESEND = 8'hFE;
    localparam logic [7:0] RPL_BAT_ER = 8'hFC;
    localparam logic [7:0] RPL_ERR0   = 8'h00;
    localparam logic [7:0] RPL_ERR1   = 8'hFF;

    localparam logic [7:0] MOD_LSHIFT = 8'h12;
    localparam logic [7:0] MOD_RSHIFT = 8'h59;
    localparam logic [7:0] MOD_CTRL   = 8'h14;
    localparam logic [7:0] MOD_ALT    = 8'h11;

    localparam int EV_W = 10;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    function automatic logic is_reply(input logic [7:0] b);
        return b == RPL_ACK || b == RPL_BAT_OK || b == RPL_ECHO || b == RPL_RESEND ||
               b == RPL_BAT_ER || b == RPL_ERR0 || b == RPL_ERR1;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word-fall-through event FIFO with sticky overflow flag.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [EV_W-1:0] din,
    input  logic            rd_en,
    output logic [EV_W-1:0] dout,
    output logic            valid,
    output logic            full,
    output logic            overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EV_W-1:0]     mem_q [DEPTH];
    logic [EV_W-1:0]     mem_d [DEPTH];
    logic                ovf_q, ovf_d;
    logic                empty, do_pop, do_push;

    assign empty   = wr_ptr_q == rd_ptr_q;
    assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign do_pop  = rd_en && !empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(do_pop);
        ovf_d    = ovf_q || (push && !do_push);
        if (do_push) mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign valid    = !empty;
    assign dout     = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign overflow = ovf_q;

endmodule

// File: rtl/ps2_kb_event_decoder.sv
// ps2_kb_event_decoder: assembles Set-2 scan-code sequences into key events and
// buffers them; define PS2_KB_MOD_STATE_EN to build modifier tracking on mod_state.
module ps2_kb_event_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int PAUSE_LEN  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    input  logic       rd_en,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       fifo_full,
    output logic       overflow,
    output logic [3:0] mod_state
);

    localparam int CW = $clog2(PAUSE_LEN + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rx_en_q;
    logic          push;
    ev_t           push_ev, head;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        push_ev = '{brk: 1'b0, ext: 1'b0, code: rx_data};
        if (rx_done_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == PFX_EXT) state_d = ST_EXT;
                    else if (rx_data == PFX_BRK) state_d = ST_BRK;
                    else if (rx_data == PFX_PAUSE) begin
                        state_d = ST_PAUSE;
                        cnt_d   = CW'(PAUSE_LEN);
                    end else push = !is_reply(rx_data);
                end
                ST_EXT: begin
                    if (rx_data == PFX_BRK) state_d = ST_EXT_BRK;
                    else if (rx_data != PFX_EXT) begin
                        push        = 1'b1;
                        push_ev.ext = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    push        = 1'b1;
                    push_ev.brk = 1'b1;
                    state_d     = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    push        = 1'b1;
                    push_ev.brk = 1'b1;
                    push_ev.ext = 1'b1;
                    state_d     = ST_IDLE;
                end
                ST_PAUSE: begin
                    // Pause bytes are counted blindly; E1/F0 inside the run are not prefixes.
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        push         = 1'b1;
                        push_ev.code = PFX_PAUSE;
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rx_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_en_q <= 1'b1;
        end
    end

    ps2_event_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (push_ev),
        .rd_en    (rd_en),
        .dout     (head),
        .valid    (ev_valid),
        .full     (fifo_full),
        .overflow (overflow)
    );

    assign rx_en   = rx_en_q;
    assign ev_code = head.code;
    assign ev_ext  = head.ext;
    assign ev_brk  = head.brk;

`ifdef PS2_KB_MOD_STATE_EN
    logic [3:0] mod_q, mod_d;

    // Shifts count only unextended; ctrl/alt track both left and right keys.
    always_comb begin
        mod_d = mod_q;
        if (push) begin
            if (!push_ev.ext && push_ev.code == MOD_LSHIFT) mod_d[0] = !push_ev.brk;
            if (!push_ev.ext && push_ev.code == MOD_RSHIFT) mod_d[1] = !push_ev.brk;
            if (push_ev.code == MOD_CTRL) mod_d[2] = !push_ev.brk;
            if (push_ev.code == MOD_ALT) mod_d[3] = !push_ev.brk;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mod_q <= '0;
        else mod_q <= mod_d;
    end

    assign mod_state = mod_q;
`else
    assign mod_state = 4'b0000;
`endif

endmodule
